// File: rtl/exec_mem_unit.sv
// Execute/memory slice of the RV32I pipeline: ALU decoder, 32-bit ALU with zero flag, word-addressed data memory.
// Define ALU_EXT_OPS_EN to add xor / sll / srl to both the decoder and the ALU.
module exec_mem_unit #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  alu_op,
  input  logic [2:0]  funct3,
  input  logic        op5,
  input  logic        funct7_5,
  output logic [2:0]  alu_control,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [31:0] alu_result,
  output logic        zero,
  input  logic        mem_write,
  input  logic [31:0] write_data,
  output logic [31:0] read_data
);

  logic [31:0] mem [DEPTH];
  logic [AW-1:0] word_idx;
  logic unused_addr_bits;

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7_5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
`ifdef ALU_EXT_OPS_EN
          3'b100:  alu_control = 3'b100;
          3'b001:  alu_control = 3'b110;
          3'b101:  alu_control = 3'b111;
`endif
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    alu_result = 32'd0;
    case (alu_control)
      3'b000: alu_result = src_a + src_b;
      3'b001: alu_result = src_a - src_b;
      3'b010: alu_result = src_a & src_b;
      3'b011: alu_result = src_a | src_b;
      3'b101: alu_result = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
`ifdef ALU_EXT_OPS_EN
      3'b100: alu_result = src_a ^ src_b;
      3'b110: alu_result = src_a << src_b[4:0];
      3'b111: alu_result = src_a >> src_b[4:0];
`endif
      default: alu_result = 32'd0;
    endcase
  end

  assign zero = (alu_result == 32'd0);

  // Byte offset and upper bits are dropped, so accesses wrap modulo DEPTH words.
  assign word_idx = alu_result[AW+1:2];
  assign unused_addr_bits = ^{alu_result[31:AW+2], alu_result[1:0]};

  // Asynchronous clear keeps every word readable as 0 while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (mem_write) begin
      mem[word_idx] <= write_data;
    end
  end

  assign read_data = mem[word_idx];

endmodule

// File: tb/tb_exec_mem_unit.sv
// Self-checking bench for exec_mem_unit: table-driven decoder/ALU vectors plus directed memory sequences.
module tb_exec_mem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        op5;
  logic        funct7_5;
  logic [2:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic        zero;
  logic        mem_write;
  logic [31:0] write_data;
  logic [31:0] read_data;

  int errors = 0;
  int checks = 0;

  exec_mem_unit #(.DEPTH(64), .AW(6)) dut (
    .clk(clk), .reset(reset), .alu_op(alu_op), .funct3(funct3), .op5(op5),
    .funct7_5(funct7_5), .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
    .alu_result(alu_result), .zero(zero), .mem_write(mem_write),
    .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        r5;
    logic        f75;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  exp_ctrl;
    logic [31:0] exp_res;
    logic        exp_zero;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic set_addr(input logic [31:0] addr);
    alu_op = 2'b00;
    funct3 = 3'b000;
    src_a  = addr;
    src_b  = 32'd0;
  endtask

  initial begin
    //             op     f3      r5    f75   a             b             ctrl    result        zero
    vecs[0]  = '{2'b10, 3'b000, 1'b1, 1'b1, 32'd5,        32'd7,        3'b001, 32'hFFFFFFFE, 1'b0};
    vecs[1]  = '{2'b10, 3'b000, 1'b0, 1'b1, 32'd5,        32'd7,        3'b000, 32'd12,       1'b0};
    vecs[2]  = '{2'b01, 3'b000, 1'b0, 1'b0, 32'h1234,     32'h1234,     3'b001, 32'd0,        1'b1};
    vecs[3]  = '{2'b10, 3'b010, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd1,        3'b101, 32'd1,        1'b0};
    vecs[4]  = '{2'b10, 3'b010, 1'b1, 1'b0, 32'd1,        32'hFFFFFFFF, 3'b101, 32'd0,        1'b1};
    vecs[5]  = '{2'b10, 3'b110, 1'b1, 1'b0, 32'hF0,       32'h0F,       3'b011, 32'hFF,       1'b0};
    vecs[6]  = '{2'b10, 3'b111, 1'b1, 1'b0, 32'hF0,       32'h0F,       3'b010, 32'h0,        1'b1};
    vecs[7]  = '{2'b00, 3'b000, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        3'b000, 32'd0,        1'b1};
    vecs[8]  = '{2'b11, 3'b111, 1'b1, 1'b1, 32'd3,        32'd4,        3'b000, 32'd7,        1'b0};
    vecs[9]  = '{2'b10, 3'b010, 1'b0, 1'b0, 32'h80000000, 32'h7FFFFFFF, 3'b101, 32'd1,        1'b0};
    vecs[10] = '{2'b10, 3'b011, 1'b1, 1'b0, 32'd2,        32'd3,        3'b000, 32'd5,        1'b0};
`ifdef ALU_EXT_OPS_EN
    vecs[11] = '{2'b10, 3'b100, 1'b1, 1'b0, 32'd6,        32'd3,        3'b100, 32'd5,        1'b0};
    vecs[12] = '{2'b10, 3'b001, 1'b1, 1'b0, 32'd1,        32'd4,        3'b110, 32'd16,       1'b0};
    vecs[13] = '{2'b10, 3'b101, 1'b1, 1'b0, 32'h80,       32'd3,        3'b111, 32'h10,       1'b0};
`else
    vecs[11] = '{2'b10, 3'b100, 1'b1, 1'b0, 32'd6,        32'd3,        3'b000, 32'd9,        1'b0};
    vecs[12] = '{2'b10, 3'b001, 1'b1, 1'b0, 32'd1,        32'd4,        3'b000, 32'd5,        1'b0};
    vecs[13] = '{2'b10, 3'b101, 1'b1, 1'b0, 32'h80,       32'd3,        3'b000, 32'h83,       1'b0};
`endif
    vecs[14] = '{2'b01, 3'b111, 1'b1, 1'b1, 32'd9,        32'd2,        3'b001, 32'd7,        1'b0};

    reset      = 1'b1;
    mem_write  = 1'b0;
    write_data = 32'd0;
    op5        = 1'b0;
    funct7_5   = 1'b0;
    set_addr(32'h64);
    #1;
    chk("reset_read", read_data, 32'd0);

    // Write attempt while reset is held must be ignored
    mem_write  = 1'b1;
    write_data = 32'hAAAA5555;
    @(posedge clk); #1;
    chk("reset_write_ignored", read_data, 32'd0);
    reset     = 1'b0;
    mem_write = 1'b0;
    #1;
    chk("post_reset_read", read_data, 32'd0);

    for (int i = 0; i < 15; i++) begin
      alu_op   = vecs[i].op;
      funct3   = vecs[i].f3;
      op5      = vecs[i].r5;
      funct7_5 = vecs[i].f75;
      src_a    = vecs[i].a;
      src_b    = vecs[i].b;
      #1;
      chk($sformatf("vec%0d_ctrl", i), {29'd0, alu_control}, {29'd0, vecs[i].exp_ctrl});
      chk($sformatf("vec%0d_result", i), alu_result, vecs[i].exp_res);
      chk($sformatf("vec%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].exp_zero});
    end

    // Store 0xDEADBEEF at byte address 0x60+4
    op5 = 1'b0; funct7_5 = 1'b0;
    alu_op = 2'b00; funct3 = 3'b000;
    src_a = 32'h60; src_b = 32'd4;
    write_data = 32'hDEADBEEF;
    mem_write  = 1'b1;
    #1;
    chk("store_addr", alu_result, 32'd100);
    chk("store_old_value", read_data, 32'd0);
    @(posedge clk); #1;
    mem_write = 1'b0;
    chk("load_100", read_data, 32'hDEADBEEF);
    set_addr(32'h164); #1;
    chk("load_wrap_164", read_data, 32'hDEADBEEF);
    set_addr(32'h65); #1;
    chk("load_lowbits_65", read_data, 32'hDEADBEEF);
    set_addr(32'h68); #1;
    chk("neighbour_68", read_data, 32'd0);

    // Unaligned store address lands on word 0x68
    set_addr(32'h6B);
    write_data = 32'h12345678;
    mem_write  = 1'b1;
    @(posedge clk); #1;
    mem_write = 1'b0;
    set_addr(32'h68); #1;
    chk("store_unaligned_68", read_data, 32'h12345678);
    set_addr(32'h64); #1;
    chk("keep_64", read_data, 32'hDEADBEEF);

    // Asynchronous reset between edges with a write pending
    write_data = 32'h11111111;
    mem_write  = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_read", read_data, 32'd0);
    @(posedge clk); #1;
    reset     = 1'b0;
    mem_write = 1'b0;
    #1;
    chk("after_reset_64", read_data, 32'd0);
    set_addr(32'h68); #1;
    chk("after_reset_68", read_data, 32'd0);

    // First write after deassertion lands on the next edge
    set_addr(32'h64);
    write_data = 32'hCAFEF00D;
    mem_write  = 1'b1;
    @(posedge clk); #1;
    mem_write = 1'b0;
    chk("first_write_after_reset", read_data, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
